lc3_mem_access_ctrl: RTL and testbench

//  Memory access controller that consumes the effective addresses produced by the LC-3 datapath.

---
 rtl/lc3_mem_access_ctrl_if.sv | 41 ++++
 rtl/lc3_mem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_lc3_mem_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_access_ctrl_if.sv
// Bus bundle between the LC-3 datapath/memory/console side and the memory access controller.
// Signal names follow the established port names of the controller.
interface lc3_mem_access_ctrl_if;
    logic [15:0] bus_in;
    logic        ld_mar;
    logic        ld_mdr;
    logic        req_valid;
    logic        req_we;
    logic        req_ready;
    logic        done;
    logic        err;
    logic [15:0] mar_out;
    logic [15:0] mdr_out;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        kb_strobe;
    logic [7:0]  kb_data;
    logic        disp_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;

    // Datapath, memory and console side
    modport master (
        output bus_in, ld_mar, ld_mdr, req_valid, req_we,
        output mem_rdata, mem_ack, kb_strobe, kb_data, disp_ready,
        input  req_ready, done, err, mar_out, mdr_out,
        input  mem_en, mem_we, mem_addr, mem_wdata, disp_valid, disp_data
    );

    // Memory access controller side
    modport slave (
        input  bus_in, ld_mar, ld_mdr, req_valid, req_we,
        input  mem_rdata, mem_ack, kb_strobe, kb_data, disp_ready,
        output req_ready, done, err, mar_out, mdr_out,
        output mem_en, mem_we, mem_addr, mem_wdata, disp_valid, disp_data
    );
endinterface

// File: rtl/lc3_mem_access_ctrl.sv
// LC-3 memory access controller: holds MAR/MDR, runs one read or write per request
// against ack-based external memory, and serves the memory-mapped keyboard/display page.
module lc3_mem_access_ctrl #(
    parameter logic [15:0] IO_BASE = 16'hFE00,
    parameter int          TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst_n,
    lc3_mem_access_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

    state_t           state, stateNext;
    logic [15:0]      mar, mdr;
    logic [7:0]       kbdr;
    logic             kbReady;
    logic             weLatched;
    logic             errFlag;
    logic [CNT_W-1:0] toCnt;
    logic [7:0]       dispData;
    logic             dispValid;

    logic             handshake;
    logic             isIoAddr;
    logic             ackIn;
    logic             timeoutHit;
    logic             kbdrRead;
    logic             ddrWrite;
    logic [15:0]      ioRdata;

    assign handshake  = bus.req_valid & bus.req_ready;
    assign isIoAddr   = (mar[15:3] == IO_BASE[15:3]);
    assign ackIn      = (state == MEM) & bus.mem_ack;
    // Ack on the timeout edge takes priority, so the timeout needs no ack
    assign timeoutHit = (state == MEM) & ~bus.mem_ack & (toCnt == TO_LAST);
    assign kbdrRead   = (state == IO) & ~weLatched & (mar[2:0] == 3'd2);
    assign ddrWrite   = (state == IO) &  weLatched & (mar[2:0] == 3'd6);

    assign bus.req_ready  = rst_n & (state == IDLE);
    assign bus.done       = (state == DONE);
    assign bus.err        = (state == DONE) & errFlag;
    assign bus.mar_out    = mar;
    assign bus.mdr_out    = mdr;
    assign bus.mem_en     = (state == MEM);
    assign bus.mem_we     = (state == MEM) & weLatched;
    assign bus.mem_addr   = mar;
    assign bus.mem_wdata  = mdr;
    assign bus.disp_valid = dispValid;
    assign bus.disp_data  = dispData;

    // I/O page read mux; unmapped and write-only offsets read as zero
    always_comb begin
        ioRdata = 16'h0000;
        case (mar[2:0])
            3'd0:    ioRdata = {kbReady, 15'b0};
            3'd2:    ioRdata = {8'h00, kbdr};
            3'd4:    ioRdata = {bus.disp_ready, 15'b0};
            default: ioRdata = 16'h0000;
        endcase
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (handshake) stateNext = isIoAddr ? IO : MEM;
            MEM:  if (ackIn || timeoutHit) stateNext = DONE;
            IO:   stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // MAR/MDR, request latch and timeout counter; an ld_mar coinciding with the
    // handshake is dropped so the accepted access keeps the address it was decoded with
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mar       <= 16'h0000;
            mdr       <= 16'h0000;
            weLatched <= 1'b0;
            errFlag   <= 1'b0;
            toCnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ld_mar && !handshake) mar <= bus.bus_in;
                    if (bus.ld_mdr) mdr <= bus.bus_in;
                    if (handshake) begin
                        weLatched <= bus.req_we;
                        toCnt     <= '0;
                        errFlag   <= 1'b0;
                    end
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        if (!weLatched) mdr <= bus.mem_rdata;
                        errFlag <= 1'b0;
                    end else if (timeoutHit) begin
                        errFlag <= 1'b1;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                IO: begin
                    if (!weLatched) mdr <= ioRdata;
                end
                default: ;
            endcase
        end
    end

    // Keyboard data/status; a new strobe wins over a same-edge KBDR read clearing the flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kbdr    <= 8'h00;
            kbReady <= 1'b0;
        end else if (bus.kb_strobe) begin
            kbdr    <= bus.kb_data;
            kbReady <= 1'b1;
        end else if (kbdrRead) begin
            kbReady <= 1'b0;
        end
    end

    // Display output register; the valid pulse lands in the DONE cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dispData  <= 8'h00;
            dispValid <= 1'b0;
        end else begin
            dispValid <= ddrWrite;
            if (ddrWrite) dispData <= mdr[7:0];
        end
    end

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// Directed scoreboard bench for lc3_mem_access_ctrl (TIMEOUT = 4).
module tb_lc3_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic        err;
        logic [15:0] mdr;
    } exp_t;
    exp_t sbQ[$];

    lc3_mem_access_ctrl_if busIf();

    lc3_mem_access_ctrl #(.IO_BASE(16'hFE00), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf.slave)
    );

    always #5 clk = ~clk;

    // Hard stop in case a wait loop misbehaves
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic loadMar(input logic [15:0] v);
        busIf.bus_in = v; busIf.ld_mar = 1'b1;
        tick();
        busIf.ld_mar = 1'b0;
    endtask

    task automatic loadMdr(input logic [15:0] v);
        busIf.bus_in = v; busIf.ld_mdr = 1'b1;
        tick();
        busIf.ld_mdr = 1'b0;
    endtask

    task automatic sbPush(input logic e, input logic [15:0] m);
        exp_t x;
        x.err = e; x.mdr = m;
        sbQ.push_back(x);
    endtask

    // Present a request for one edge; returns in the first cycle after the handshake
    task automatic issue(input logic we);
        busIf.req_valid = 1'b1; busIf.req_we = we;
        tick();
        busIf.req_valid = 1'b0; busIf.req_we = 1'b0;
    endtask

    // Wait (bounded) for done, compare against the scoreboard, then check the pulse ends
    task automatic waitDone(input string tag, input int bound);
        int   n = 0;
        exp_t e;
        while (busIf.done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 16'(busIf.done), 16'd1);
        chk({tag, "_sbq"}, 16'(sbQ.size() > 0), 16'd1);
        if (busIf.done === 1'b1 && sbQ.size() > 0) begin
            e = sbQ.pop_front();
            chk({tag, "_err"}, 16'(busIf.err), 16'(e.err));
            chk({tag, "_mdr"}, busIf.mdr_out, e.mdr);
            chk({tag, "_rdyInDone"}, 16'(busIf.req_ready), 16'd0);
        end
        tick();
        chk({tag, "_donePulse"}, 16'(busIf.done), 16'd0);
        chk({tag, "_rdyAfter"}, 16'(busIf.req_ready), 16'd1);
    endtask

    // Directed sequence
    initial begin
        int n;
        rst_n = 1'b0;
        busIf.bus_in = 16'h0; busIf.ld_mar = 1'b0; busIf.ld_mdr = 1'b0;
        busIf.req_valid = 1'b0; busIf.req_we = 1'b0;
        busIf.mem_rdata = 16'h0; busIf.mem_ack = 1'b0;
        busIf.kb_strobe = 1'b0; busIf.kb_data = 8'h00; busIf.disp_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ready", 16'(busIf.req_ready), 16'd0);
        chk("rst_memEn", 16'(busIf.mem_en), 16'd0);
        chk("rst_mar", busIf.mar_out, 16'h0000);
        chk("rst_mdr", busIf.mdr_out, 16'h0000);
        chk("rst_done", 16'(busIf.done), 16'd0);
        chk("rst_dispValid", 16'(busIf.disp_valid), 16'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 16'(busIf.req_ready), 16'd1);

        // T1: write x1234 to x3000, ack after 3 held cycles
        loadMar(16'h3000);
        loadMdr(16'h1234);
        chk("T1_mar", busIf.mar_out, 16'h3000);
        chk("T1_mdrLoad", busIf.mdr_out, 16'h1234);
        sbPush(1'b0, 16'h1234);
        issue(1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("T1_memEn", 16'(busIf.mem_en), 16'd1);
            chk("T1_memWe", 16'(busIf.mem_we), 16'd1);
            chk("T1_addr", busIf.mem_addr, 16'h3000);
            chk("T1_wdata", busIf.mem_wdata, 16'h1234);
            if (i == 2) begin
                busIf.mem_ack = 1'b1; busIf.mem_rdata = 16'hDEAD;
            end
            tick();
        end
        busIf.mem_ack = 1'b0;
        chk("T1_memEnDrop", 16'(busIf.mem_en), 16'd0);
        waitDone("T1", 0);

        // T2: read x4000, ack in the same cycle mem_en rises
        loadMar(16'h4000);
        sbPush(1'b0, 16'hBEEF);
        issue(1'b0);
        chk("T2_memEn", 16'(busIf.mem_en), 16'd1);
        chk("T2_memWe", 16'(busIf.mem_we), 16'd0);
        busIf.mem_ack = 1'b1; busIf.mem_rdata = 16'hBEEF;
        tick();
        busIf.mem_ack = 1'b0;
        waitDone("T2", 0);

        // T3a: read x5000 with no ack -> timeout after 4 mem_en cycles
        loadMar(16'h5000);
        sbPush(1'b1, 16'hBEEF);
        issue(1'b0);
        n = 0;
        while (busIf.mem_en === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("T3_toCycles", 16'(n), 16'd4);
        waitDone("T3a", 0);

        // T3b: ack on the 4th cycle wins over the timeout
        sbPush(1'b0, 16'h7777);
        issue(1'b0);
        tick(); tick(); tick();
        chk("T3b_memEn4", 16'(busIf.mem_en), 16'd1);
        busIf.mem_ack = 1'b1; busIf.mem_rdata = 16'h7777;
        tick();
        busIf.mem_ack = 1'b0;
        waitDone("T3b", 0);

        // T4: keyboard status/data
        busIf.kb_strobe = 1'b1; busIf.kb_data = 8'h41;
        tick();
        busIf.kb_strobe = 1'b0;
        loadMar(16'hFE00);
        sbPush(1'b0, 16'h8000);
        issue(1'b0);
        chk("T4_ioMemEn", 16'(busIf.mem_en), 16'd0);
        waitDone("T4_kbsr1", 2);
        loadMar(16'hFE02);
        sbPush(1'b0, 16'h0041);
        issue(1'b0);
        waitDone("T4_kbdr", 2);
        loadMar(16'hFE00);
        sbPush(1'b0, 16'h0000);
        issue(1'b0);
        waitDone("T4_kbsr0", 2);
        busIf.kb_strobe = 1'b1; busIf.kb_data = 8'h42;
        tick();
        busIf.kb_strobe = 1'b0;
        loadMar(16'hFE02);
        sbPush(1'b0, 16'h0042);
        issue(1'b0);
        busIf.kb_strobe = 1'b1; busIf.kb_data = 8'h43;
        tick();
        busIf.kb_strobe = 1'b0;
        waitDone("T4_kbdrRace", 0);
        loadMar(16'hFE00);
        sbPush(1'b0, 16'h8000);
        issue(1'b0);
        waitDone("T4_flagKept", 2);
        loadMar(16'hFE02);
        sbPush(1'b0, 16'h0043);
        issue(1'b0);
        waitDone("T4_newChar", 2);

        // T5: display write and status
        loadMdr(16'h0A5A);
        loadMar(16'hFE06);
        sbPush(1'b0, 16'h0A5A);
        issue(1'b1);
        chk("T5_ioMemEn", 16'(busIf.mem_en), 16'd0);
        chk("T5_dvInIo", 16'(busIf.disp_valid), 16'd0);
        tick();
        chk("T5_dispValid", 16'(busIf.disp_valid), 16'd1);
        chk("T5_dispData", 16'(busIf.disp_data), 16'h005A);
        chk("T5_memEnDone", 16'(busIf.mem_en), 16'd0);
        waitDone("T5_ddr", 0);
        chk("T5_dvPulse", 16'(busIf.disp_valid), 16'd0);
        chk("T5_dataHeld", 16'(busIf.disp_data), 16'h005A);
        busIf.disp_ready = 1'b1;
        loadMar(16'hFE04);
        sbPush(1'b0, 16'h8000);
        issue(1'b0);
        waitDone("T5_dsr", 2);

        // ld_mar coinciding with the handshake: access uses the old MAR
        loadMar(16'h2000);
        busIf.bus_in = 16'h7000; busIf.ld_mar = 1'b1;
        sbPush(1'b0, 16'h55AA);
        issue(1'b0);
        busIf.ld_mar = 1'b0;
        chk("LD_oldAddr", busIf.mem_addr, 16'h2000);
        busIf.mem_ack = 1'b1; busIf.mem_rdata = 16'h55AA;
        tick();
        busIf.mem_ack = 1'b0;
        waitDone("LD", 0);

        // T6: ld_mar ignored in MEM, reset aborts the access
        loadMar(16'h6000);
        loadMdr(16'h1111);
        issue(1'b0);
        busIf.bus_in = 16'h9999; busIf.ld_mar = 1'b1;
        tick();
        busIf.ld_mar = 1'b0;
        chk("T6_marKept", busIf.mar_out, 16'h6000);
        chk("T6_memEn", 16'(busIf.mem_en), 16'd1);
        rst_n = 1'b0;
        tick();
        chk("T6_memEnRst", 16'(busIf.mem_en), 16'd0);
        chk("T6_marRst", busIf.mar_out, 16'h0000);
        chk("T6_mdrRst", busIf.mdr_out, 16'h0000);
        chk("T6_doneRst", 16'(busIf.done), 16'd0);
        chk("T6_readyRst", 16'(busIf.req_ready), 16'd0);
        rst_n = 1'b1;
        tick();
        chk("T6_noDone", 16'(busIf.done), 16'd0);
        chk("T6_ready", 16'(busIf.req_ready), 16'd1);
        chk("sb_empty", 16'(sbQ.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
